// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared types and constants for the pattern scan sequencer
package pattern_scan_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_DEPTH  = 9;
    localparam int DEF_ADDR_W = 4;

    localparam int NUM_WIN = DEF_WORD_W - DEF_PAT_W + 1;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Number of window positions for an arbitrary word/pattern pairing.
    function automatic int num_win(input int word_w, input int pat_w);
        return word_w - pat_w + 1;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_bcd_sat_counter.sv
// rtl/pattern_scan_ctrl_bcd_sat_counter.sv - BCD match counter saturating at 9 with sticky overflow
module bcd_sat_counter
    import pattern_scan_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] count_o,
    output logic       overflow_o
);

    logic [3:0] count_q, count_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr_i) begin
            count_d    = 4'd0;
            overflow_d = 1'b0;
        end else if (inc_i) begin
            // Once saturated, further matches only flag the lost counts.
            if (count_q == BCD_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - walks data memory and counts windows matching a latched pattern
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [PAT_W-1:0]  x_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic [2:0]        sel1_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        count_o,
    output logic              overflow_o
);

    localparam logic [2:0]        LAST_K = 3'(num_win(WORD_W, PAT_W) - 1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    state_e state_q, state_d;

    logic [PAT_W-1:0]  x_q, x_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        sel1_q, sel1_d;

    logic start_acc;
    logic match;
    logic last_win;
    logic last_addr;

    assign start_acc = (state_q == ST_IDLE) && start_i && !abort_i;
    assign last_win  = (sel1_q >= LAST_K);
    assign last_addr = (addr_q >= LAST_A);

    // Window k is LSB-aligned: k=0 selects word_q[PAT_W-1:0].
    logic [WORD_W-1:0] word_shr;
    assign word_shr = word_q >> sel1_q;
    assign match    = (word_shr[PAT_W-1:0] == x_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (start_acc) begin
                state_d = ST_FETCH;
            end
        end else if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT:  state_d = ST_SCAN;
                ST_SCAN: begin
                    if (!last_win) begin
                        state_d = ST_SCAN;
                    end else if (!last_addr) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd_o = (state_q == ST_FETCH);
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);
    end

    always_comb begin
        x_d    = x_q;
        word_d = word_q;
        addr_d = addr_q;
        sel1_d = sel1_q;
        if (start_acc) begin
            x_d    = x_i;
            addr_d = '0;
            sel1_d = 3'd0;
        end else if (state_q != ST_IDLE && abort_i) begin
            sel1_d = 3'd0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    word_d = mem_data_i;
                    sel1_d = 3'd0;
                end
                ST_SCAN: begin
                    if (!last_win) begin
                        sel1_d = sel1_q + 3'd1;
                    end else begin
                        sel1_d = 3'd0;
                        if (!last_addr) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            word_q <= '0;
            addr_q <= '0;
            sel1_q <= 3'd0;
        end else begin
            x_q    <= x_d;
            word_q <= word_d;
            addr_q <= addr_d;
            sel1_q <= sel1_d;
        end
    end

    assign mem_addr_o = addr_q;
    assign sel1_o     = sel1_q;

    bcd_sat_counter u_count (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (start_acc),
        .inc_i      ((state_q == ST_SCAN) && match),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic       abort_i;
    logic [3:0] x_i;
    logic [3:0] mem_addr_o;
    logic       mem_rd_o;
    logic [7:0] mem_data_i;
    logic [2:0] sel1_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] count_o;
    logic       overflow_o;

    logic [7:0] mem [9];

    int checks = 0;
    int errors = 0;

    pattern_scan_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .x_i        (x_i),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .sel1_o     (sel1_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_matches(input logic [3:0] p);
        int n;
        n = 0;
        for (int w = 0; w < 9; w++)
            for (int k = 0; k <= 4; k++)
                if (((mem[w] >> k) & 8'h0F) == {4'h0, p}) n++;
        return n;
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 9; i++) mem[i] = v;
    endtask

    // Full scan: start sampled at edge E0, cycle c is the cycle after edge E0+c-1.
    task automatic run_scan(input string tag, input logic [3:0] p, input bit trace, input int restart_at);
        int n, exp_cnt, w, ph;
        n = model_matches(p);
        exp_cnt = (n > 9) ? 9 : n;
        @(negedge clk);
        x_i = p;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        x_i = ~p;
        for (int c = 1; c <= 65; c++) begin
            if (c > 1) @(negedge clk);
            start_i = (c == restart_at) ? 1'b1 : 1'b0;
            if (c <= 63) begin
                check({tag, " busy"}, busy_o, 1);
                check({tag, " done_early"}, done_o, 0);
                if (trace) begin
                    w = (c - 1) / 7;
                    ph = (c - 1) % 7;
                    check({tag, " mem_rd"}, mem_rd_o, (ph == 0) ? 1 : 0);
                    if (ph == 0) check({tag, " mem_addr"}, mem_addr_o, w);
                    if (ph >= 2) check({tag, " sel1"}, sel1_o, ph - 2);
                end
            end else if (c == 64) begin
                check({tag, " done"}, done_o, 1);
                check({tag, " busy_done"}, busy_o, 1);
            end else begin
                check({tag, " done_pulse"}, done_o, 0);
                check({tag, " busy_idle"}, busy_o, 0);
                check({tag, " count"}, count_o, exp_cnt);
                check({tag, " overflow"}, overflow_o, (n > 9) ? 1 : 0);
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        bit seen_done;
        rst_ni = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        x_i = 4'h0;
        mem_data_i = 8'h00;
        fill(8'h00);
        #23;
        check("rst mem_addr", mem_addr_o, 0);
        check("rst mem_rd", mem_rd_o, 0);
        check("rst sel1", sel1_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst count", count_o, 0);
        check("rst overflow", overflow_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        run_scan("zero", 4'hF, 1, 0);

        fill(8'h00);
        mem[0] = 8'hA7;
        run_scan("a7", 4'h7, 0, 0);

        fill(8'h00);
        mem[3] = 8'h55;
        run_scan("w3_55", 4'h5, 0, 0);

        fill(8'hFF);
        run_scan("sat", 4'hF, 1, 0);

        // Abort in the last SCAN cycle of word 1 (cycle 14).
        fill(8'hFF);
        @(negedge clk);
        x_i = 4'hF;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("abort pre_count", count_o, 0);
        repeat (13) @(negedge clk);
        check("abort sel1", sel1_o, 4);
        check("abort pre_busy", busy_o, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort busy", busy_o, 0);
        check("abort mem_rd", mem_rd_o, 0);
        check("abort count", count_o, 9);
        seen_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done_o || busy_o) seen_done = 1'b1;
        end
        check("abort no_done", seen_done, 0);

        // start and abort together in IDLE: nothing starts.
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy_o || mem_rd_o) seen_done = 1'b1;
            @(negedge clk);
        end
        check("both no_busy", seen_done, 0);
        check("both count_kept", count_o, 9);

        fill(8'h00);
        mem[2] = 8'h3C;
        run_scan("restart", 4'hF, 1, 20);

        // Reset mid-scan.
        fill(8'hFF);
        @(negedge clk);
        x_i = 4'hF;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (29) @(negedge clk);
        check("midrst pre_count", count_o, 9);
        check("midrst pre_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst mem_addr", mem_addr_o, 0);
        check("midrst mem_rd", mem_rd_o, 0);
        check("midrst sel1", sel1_o, 0);
        check("midrst busy", busy_o, 0);
        check("midrst done", done_o, 0);
        check("midrst count", count_o, 0);
        check("midrst overflow", overflow_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        fill(8'h00);
        mem[8] = 8'hF0;
        run_scan("post_rst", 4'hF, 1, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) mem[i] = 8'($urandom);
            run_scan("rand", 4'($urandom), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Sequencer for the pattern-match datapath. On `start` it walks every word of the DEPTH-entry data memory and, for each word, steps the window select through every PAT_W-bit window position. It compares each window against the latched pattern and accumulates a saturating BCD match count for the 7-segment decoder. A start/busy/done handshake lets the top level re-run a scan with a new pattern.

Parameters:
WORD_W, 8, data memory word width
PAT_W, 4, pattern/window width
DEPTH, 9, number of memory words scanned (addresses 0..DEPTH-1)
ADDR_W, 4, memory address width (must satisfy 2**ADDR_W >= DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
start  in  1  request a scan; sampled only in IDLE
abort  in  1  synchronous abort of a running scan
x  in  PAT_W  pattern to search for; latched on start accept
mem_addr  out  ADDR_W  data memory read address
mem_rd  out  1  read strobe; data returns one cycle later
mem_data  in  WORD_W  memory read data, valid the cycle after mem_rd
sel1  out  3  current window offset k (0..WORD_W-PAT_W)
busy  out  1  high from start accept until the DONE state exits
done  out  1  one-cycle pulse: scan finished normally
count  out  4  BCD match count, 0..9
overflow  out  1  sticky flag: a match occurred while count==9

Behaviour:
- Reset (async, rst=0): state=IDLE; mem_addr=0, mem_rd=0, sel1=0, busy=0, done=0, count=0, overflow=0; latched pattern and word register cleared.
- States:
  - IDLE: if start=1 and abort=0, latch x, clear count and overflow, set addr=0, go to FETCH.
  - FETCH: mem_rd=1, mem_addr=addr, go to WAIT.
  - WAIT: mem_rd=0; at the end of the cycle capture mem_data into word_q; sel1=0; go to SCAN.
  - SCAN: one window per cycle. match = (word_q[sel1+PAT_W-1 : sel1] == x_q). If sel1 < WORD_W-PAT_W, sel1++ and stay in SCAN. Otherwise, if addr < DEPTH-1, addr++ and go to FETCH; else go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Window ordering: offset k is LSB-aligned, so k=0 selects bits [3:0] and k=4 selects bits [7:4].
- Timing per word: 2 + (WORD_W-PAT_W+1) cycles, which is 7 at the defaults. With start sampled at edge E0, done is high in the cycle after edge E0+DEPTH*7 (cycle 64 at defaults).
- count increments on the clock edge ending any SCAN cycle with match=1.
  - At count==9 a match does not increment; it sets overflow=1 instead. Overflow stays set until the next start accept or reset.
  - count and overflow hold after done until the next start accept.
- busy is high in FETCH, WAIT, SCAN and DONE; it is low in IDLE.
- start while busy is ignored; no queueing.
- abort=1 in any non-IDLE state: go to IDLE next cycle; no done pulse; mem_rd=0; count keeps its partial value.
- start and abort both high in IDLE: abort wins and no scan starts.
- Reset mid-scan: immediate return to reset values, including count.
- sel1 and mem_addr are registered outputs; there are no combinational paths from x or mem_data to outputs.

Decomposition:
- Shared package pattern_scan_pkg:
  - state encoding (IDLE, FETCH, WAIT, SCAN, DONE);
  - NUM_WIN = WORD_W-PAT_W+1;
  - BCD_MAX = 9.
- Sub-module bcd_sat_counter: ports clk, rst, clr, inc; outputs count[3:0] and overflow. It implements saturate-at-9 and the sticky overflow.
- Window compare stays inline in pattern_scan_ctrl.

Test Plan:
- Memory all 8'h00, x=4'hF, pulse start → sel1 cycles 0..4 per word, mem_addr 0..8; done pulses in cycle 64; count=0, overflow=0.
- Word0=8'hA7, others 8'h00, x=4'h7 → only word0 window k=0 matches (k=1..4 give 3, 9, 4, A); count=1 at done.
- Word3=8'h55, others 8'h00, x=4'h5 → matches at k=0, 2, 4; count=3 at done.
- Memory all 8'hFF, x=4'hF (45 matches) → count reaches 9 on the 9th match and stays 9; overflow=1; done still pulses in cycle 64.
- Start with all 8'hFF, x=4'hF; pulse abort in the SCAN cycle of word 1 → IDLE next cycle, busy=0, no done, count=9. Then pulse start and abort high together → no scan starts, busy stays 0.
- Start a scan; assert start again mid-scan → ignored, done still at cycle 64. Then drop rst during a later scan → all outputs zero immediately and state IDLE; a new start after rst=1 completes normally.
